// File: rtl/AocPkg.sv
// Shared definitions for the input loader and the joltage solver:
// ROM address type, ASCII constants and loader FSM states.
package AocPkg;

  // 32 KiB image: room for a full puzzle input plus the EOT marker.
  localparam int ROM_ADDR_BITS = 15;

  typedef logic [ROM_ADDR_BITS-1:0] RomAddr_t;

  localparam logic [7:0] ASCII_EOT = 8'h04;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TERM  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } loader_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/input_loader.sv
// Streams the ASCII puzzle input into the solver ROM: digits packed from
// address 0 with line terminators stripped, then a single EOT byte.
// Malformed lines or a full ROM park the loader in a sticky error state.
module input_loader
  import AocPkg::*;
#(
  parameter int BATS_PER_BANK   = 100,
  parameter int BANK_COUNT_BITS = 16
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       InValid,
  input  logic [7:0]                 InData,
  input  logic                       InLast,
  output logic                       InReady,
  output logic                       WrEn,
  output RomAddr_t                   WrAddr,
  output logic [7:0]                 WrData,
  output logic [BANK_COUNT_BITS-1:0] BankCount,
  output logic                       Done,
  output logic                       Error
);

  localparam int BAT_BITS = $clog2(BATS_PER_BANK) + 1;
  localparam logic [BAT_BITS-1:0] BAT_FULL = BAT_BITS'(BATS_PER_BANK);

  typedef struct packed {
    loader_state_t              state;
    RomAddr_t                   ptr;
    logic [BAT_BITS-1:0]        bat_cnt;
    logic [BANK_COUNT_BITS-1:0] bank_cnt;
    logic                       wr_en;
    RomAddr_t                   wr_addr;
    logic [7:0]                 wr_data;
  } loader_regs_t;

  loader_regs_t r_reg;

  logic                       byte_err;
  logic                       do_write;
  logic                       last_err;
  logic [BAT_BITS-1:0]        bat_step;
  logic [BANK_COUNT_BITS-1:0] bank_step;
  logic [BAT_BITS-1:0]        bat_final;
  logic [BANK_COUNT_BITS-1:0] bank_final;

  // Classify the presented byte and work out the counters after it, then
  // apply the end-of-file rule on top of that post-byte state.
  always_comb begin
    byte_err  = 1'b0;
    do_write  = 1'b0;
    bat_step  = r_reg.bat_cnt;
    bank_step = r_reg.bank_cnt;
    if (is_digit(InData)) begin
      // A full bank without newline, or no address left for EOT, is fatal.
      if ((r_reg.bat_cnt == BAT_FULL) || (&r_reg.ptr)) begin
        byte_err = 1'b1;
      end else begin
        do_write = 1'b1;
        bat_step = r_reg.bat_cnt + 1'b1;
      end
    end else if (InData == ASCII_CR) begin
      byte_err = 1'b0;
    end else if (InData == ASCII_LF) begin
      if (r_reg.bat_cnt == BAT_FULL) begin
        bat_step  = '0;
        bank_step = r_reg.bank_cnt + 1'b1;
      end else if (r_reg.bat_cnt != '0) begin
        byte_err = 1'b1;
      end
    end else begin
      byte_err = 1'b1;
    end

    bat_final  = bat_step;
    bank_final = bank_step;
    last_err   = 1'b0;
    if (InLast) begin
      // File may end without a trailing newline: a full bank still counts.
      if (bat_step == BAT_FULL) begin
        bat_final  = '0;
        bank_final = bank_step + 1'b1;
      end else if (bat_step != '0) begin
        last_err = 1'b1;
      end
    end
  end

  // Loader FSM with registered write port; reset drops any pending write.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_reg <= '0;
    end else begin
      r_reg.wr_en <= 1'b0;
      case (r_reg.state)
        S_IDLE: r_reg.state <= S_LOAD;
        S_LOAD: begin
          if (InValid) begin
            if (byte_err) begin
              r_reg.state <= S_ERROR;
            end else begin
              if (do_write) begin
                r_reg.wr_en   <= 1'b1;
                r_reg.wr_addr <= r_reg.ptr;
                r_reg.wr_data <= InData;
                r_reg.ptr     <= r_reg.ptr + 1'b1;
              end
              r_reg.bat_cnt  <= bat_final;
              r_reg.bank_cnt <= bank_final;
              if (InLast) begin
                r_reg.state <= last_err ? S_ERROR : S_TERM;
              end
            end
          end
        end
        S_TERM: begin
          r_reg.wr_en   <= 1'b1;
          r_reg.wr_addr <= r_reg.ptr;
          r_reg.wr_data <= ASCII_EOT;
          r_reg.state   <= S_DONE;
        end
        S_DONE:  r_reg.state <= S_DONE;
        S_ERROR: r_reg.state <= S_ERROR;
        default: r_reg.state <= S_ERROR;
      endcase
    end
  end

  assign InReady   = (r_reg.state == S_LOAD);
  assign Done      = (r_reg.state == S_DONE);
  assign Error     = (r_reg.state == S_ERROR);
  assign WrEn      = r_reg.wr_en;
  assign WrAddr    = r_reg.wr_addr;
  assign WrData    = r_reg.wr_data;
  assign BankCount = r_reg.bank_cnt;

endmodule

// File: tb/tb_input_loader.sv
// Self-checking bench for input_loader with BATS_PER_BANK=4: table vectors,
// hand-written reset sequences, randomized well-formed files with stalls,
// and the ROM-capacity boundary.
module tb_input_loader;
  import AocPkg::*;

  localparam int BATS     = 4;
  localparam int BCB      = 16;
  localparam int MEM_SIZE = 1 << ROM_ADDR_BITS;

  logic           Clk = 1'b0;
  logic           Rst_n = 1'b0;
  logic           InValid = 1'b0;
  logic [7:0]     InData = 8'h00;
  logic           InLast = 1'b0;
  logic           InReady;
  logic           WrEn;
  RomAddr_t       WrAddr;
  logic [7:0]     WrData;
  logic [BCB-1:0] BankCount;
  logic           Done;
  logic           Error;

  input_loader #(.BATS_PER_BANK(BATS), .BANK_COUNT_BITS(BCB)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InData(InData),
    .InLast(InLast), .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .BankCount(BankCount), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [8*16-1:0] txt;
    int              txt_len;
    logic [8*16-1:0] img;
    int              img_len;
    int              banks;
    bit              done;
    bit              err;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         wr_cnt = 0;
  string      tag = "init";
  bit         written [MEM_SIZE];
  logic [7:0] mem [MEM_SIZE];
  logic [7:0] exp_img [$];
  logic [7:0] rnd_q [$];
  vec_t       vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string s, input string img, input int banks,
                              input bit done, input bit err);
    vec_t v;
    v.txt = '0;
    v.img = '0;
    v.txt_len = s.len();
    v.img_len = img.len();
    for (int i = 0; i < s.len(); i++) v.txt[8*i +: 8] = s[i];
    for (int i = 0; i < img.len(); i++) v.img[8*i +: 8] = img[i];
    v.banks = banks;
    v.done = done;
    v.err = err;
    return v;
  endfunction

  // One clock: note whether a transfer happens on this edge, then log any
  // write that the edge produced. A digit write must belong to this transfer.
  task automatic tick(output bit xfer);
    logic [7:0] d;
    xfer = (InValid === 1'b1) && (InReady === 1'b1);
    d = InData;
    @(posedge Clk);
    #1;
    if (WrEn === 1'b1) begin
      wr_cnt++;
      written[WrAddr] = 1'b1;
      mem[WrAddr] = WrData;
      if (WrData != ASCII_EOT)
        chk("write_one_cycle_after_transfer", 32'(xfer && (d == WrData)), 32'd1);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit last, input int maxgap);
    bit x;
    int n;
    repeat ($urandom_range(maxgap, 0)) begin
      InValid = 1'b0;
      InData = 8'($urandom);
      InLast = 1'($urandom);
      tick(x);
    end
    InValid = 1'b1;
    InData = b;
    InLast = last;
    n = 0;
    do begin
      tick(x);
      n++;
    end while (!x && n < 20);
    chk("transfer_accepted", 32'(x), 32'd1);
    InValid = 1'b0;
    InLast = 1'b0;
  endtask

  task automatic do_reset();
    bit x;
    Rst_n = 1'b0;
    InValid = 1'b0;
    InLast = 1'b0;
    tick(x);
    chk("rst_in_ready", 32'(InReady), 32'd0);
    chk("rst_wr_en", 32'(WrEn), 32'd0);
    chk("rst_wr_addr", 32'(WrAddr), 32'd0);
    chk("rst_wr_data", 32'(WrData), 32'd0);
    chk("rst_bank_count", 32'(BankCount), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    tick(x);
    Rst_n = 1'b1;
    for (int i = 0; i < MEM_SIZE; i++) written[i] = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic check_result(input int banks, input bit done, input bit err);
    bit x;
    int n_exp;
    int sz;
    repeat (4) begin
      InValid = 1'b1;
      InData = 8'h37;
      InLast = 1'b0;
      tick(x);
      chk("no_accept_after_end", 32'(x), 32'd0);
    end
    InValid = 1'b0;
    chk("done", 32'(Done), 32'(done));
    chk("error", 32'(Error), 32'(err));
    chk("bank_count", 32'(BankCount), 32'(banks));
    chk("in_ready_end", 32'(InReady), 32'd0);
    sz = exp_img.size();
    n_exp = sz + (done ? 1 : 0);
    chk("write_count", 32'(wr_cnt), 32'(n_exp));
    for (int k = 0; k < sz; k++)
      chk($sformatf("image[%0d]", k), written[k] ? {24'd0, mem[k]} : 32'hFFFF_FFFF,
          {24'd0, exp_img[k]});
    if (done)
      chk("eot_after_digits", written[sz] ? {24'd0, mem[sz]} : 32'hFFFF_FFFF,
          {24'd0, ASCII_EOT});
  endtask

  task automatic load_string(input string s);
    exp_img.delete();
    for (int k = 0; k < s.len(); k++) exp_img.push_back(s[k]);
  endtask

  // Well-formed random file: full banks, optional CR, optional blank lines,
  // optional missing final newline. Reference image = all digits in order.
  task automatic build_random(output int nb);
    logic [7:0] d;
    nb = $urandom_range(5, 1);
    rnd_q.delete();
    exp_img.delete();
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(3, 0) == 0) rnd_q.push_back(ASCII_LF);
      repeat (BATS) begin
        d = 8'(32'(ASCII_0) + $urandom_range(9, 0));
        rnd_q.push_back(d);
        exp_img.push_back(d);
      end
      if ($urandom_range(1, 0) == 1) rnd_q.push_back(ASCII_CR);
      if (b != nb - 1 || $urandom_range(1, 0) == 1) rnd_q.push_back(ASCII_LF);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    bit x;
    vecs[0]  = mk("1234\n5678\n", "12345678", 2, 1'b1, 1'b0);
    vecs[1]  = mk("1234\015\n9876", "12349876", 2, 1'b1, 1'b0);
    vecs[2]  = mk("123\n", "123", 0, 1'b0, 1'b1);
    vecs[3]  = mk("12345", "1234", 0, 1'b0, 1'b1);
    vecs[4]  = mk("\n1111\n\n", "1111", 1, 1'b1, 1'b0);
    vecs[5]  = mk("12a", "12", 0, 1'b0, 1'b1);
    vecs[6]  = mk("1\004", "1", 0, 1'b0, 1'b1);
    vecs[7]  = mk("\n", "", 0, 1'b1, 1'b0);
    vecs[8]  = mk("1234\015", "1234", 1, 1'b1, 1'b0);
    vecs[9]  = mk("4321", "4321", 1, 1'b1, 1'b0);
    vecs[10] = mk("9999\n00000", "99990000", 1, 1'b0, 1'b1);

    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      do_reset();
      exp_img.delete();
      for (int k = 0; k < vecs[i].img_len; k++) exp_img.push_back(vecs[i].img[8*k +: 8]);
      for (int k = 0; k < vecs[i].txt_len; k++)
        send(vecs[i].txt[8*k +: 8], k == vecs[i].txt_len - 1, 0);
      check_result(vecs[i].banks, vecs[i].done, vecs[i].err);
      $display("vector %0d: banks=%0d done=%0d error=%0d writes=%0d",
               i, BankCount, Done, Error, wr_cnt);
    end

    // Reset mid-load, then a fresh file reloads from address 0.
    tag = "reset_mid_load";
    do_reset();
    send("1", 1'b0, 0);
    send("2", 1'b0, 0);
    send("3", 1'b0, 0);
    do_reset();
    send("4", 1'b0, 1);
    send("3", 1'b0, 1);
    send("2", 1'b0, 1);
    send("1", 1'b0, 1);
    send(ASCII_LF, 1'b1, 1);
    load_string("4321");
    check_result(1, 1'b1, 1'b0);
    $display("reset_mid_load: banks=%0d done=%0d writes=%0d", BankCount, Done, wr_cnt);

    // Reset while the EOT write is pending: it must not appear.
    tag = "reset_in_term";
    do_reset();
    for (int k = 0; k < 4; k++) send(8'(32'(ASCII_0) + k), k == 3, 0);
    do_reset();
    tick(x);
    chk("no_eot_after_reset", 32'(wr_cnt), 32'd0);
    send(ASCII_LF, 1'b1, 0);
    load_string("");
    check_result(0, 1'b1, 1'b0);
    $display("reset_in_term: done=%0d writes=%0d", Done, wr_cnt);

    // Random files, each loaded unstalled and then with random stalls.
    for (int it = 0; it < 20; it++) begin
      build_random(nb);
      for (int g = 0; g < 2; g++) begin
        tag = $sformatf("rand%0d_gap%0d", it, g * 3);
        do_reset();
        for (int k = 0; k < rnd_q.size(); k++) send(rnd_q[k], k == rnd_q.size() - 1, g * 3);
        check_result(nb, 1'b1, 1'b0);
        $display("random %0d gap=%0d: bytes=%0d banks=%0d writes=%0d",
                 it, g * 3, rnd_q.size(), BankCount, wr_cnt);
      end
    end

    // Capacity: 32767 digits fill every address but the last, so the next
    // digit has no room for EOT and must be refused.
    tag = "capacity";
    do_reset();
    for (int b = 0; b < (MEM_SIZE - 1) / BATS; b++) begin
      for (int j = 0; j < BATS; j++) send(8'(32'(ASCII_0) + (b + j) % 10), 1'b0, 0);
      send(ASCII_LF, 1'b0, 0);
    end
    send("5", 1'b0, 0);
    send("6", 1'b0, 0);
    send("7", 1'b0, 0);
    send("8", 1'b0, 0);
    repeat (3) tick(x);
    chk("cap_error", 32'(Error), 32'd1);
    chk("cap_done", 32'(Done), 32'd0);
    chk("cap_bank_count", 32'(BankCount), 32'((MEM_SIZE - 1) / BATS));
    chk("cap_write_count", 32'(wr_cnt), 32'(MEM_SIZE - 1));
    chk("cap_last_digit", {24'd0, mem[MEM_SIZE-2]}, 32'h37);
    chk("cap_top_unwritten", 32'(written[MEM_SIZE-1]), 32'd0);
    $display("capacity: banks=%0d error=%0d writes=%0d", BankCount, Error, wr_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_loader.md
INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 Parameter: BATS_PER_BANK, default 100, number of digit characters in every bank (line).
REQ-002 Parameter: BANK_COUNT_BITS, default 16, width of the completed-bank counter.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  synchronous, active-low reset, sampled on rising edge of Clk.
REQ-005 InValid  input  1  upstream byte valid.
REQ-006 InData  input  8  upstream ASCII byte.
REQ-007 InLast  input  1  marks the final byte of the input file; qualified by InValid.
REQ-008 InReady  output  1  loader accepts the byte this cycle; transfer = InValid && InReady.
REQ-009 WrEn  output  1  memory write strobe.
REQ-010 WrAddr  output  RomAddr_t  memory write address.
REQ-011 WrData  output  8  memory write data.
REQ-012 BankCount  output  BANK_COUNT_BITS  number of complete banks written.
REQ-013 Done  output  1  image complete, EOT written; sticky.
REQ-014 Error  output  1  malformed input or capacity exceeded; sticky.

Function
REQ-015 Purpose: build the memory image consumed by the joltage solver: digit bytes packed contiguously from address 0, no line terminators, one ASCII EOT (8'h04) after the last digit.
REQ-016 FSM states: S_IDLE, S_LOAD, S_TERM, S_DONE, S_ERROR; S_IDLE -> S_LOAD unconditionally on the first cycle after reset.
REQ-017 InReady SHALL be 1 only in S_LOAD, and 0 in every other state.
REQ-018 WrEn/WrAddr/WrData SHALL be registered; a write appears exactly 1 cycle after the accepting transfer, and WrEn is high for that single cycle.
REQ-019 Accepted digit '0'-'9' (8'h30-8'h39): write the byte unchanged at the next-address pointer; pointer +1; in-bank battery count +1.
REQ-020 Accepted '\r' (8'h0D): no write, no state change.
REQ-021 Accepted '\n' (8'h0A): no write; if battery count == BATS_PER_BANK -> BankCount +1 and battery count := 0; if battery count == 0 -> ignored (blank line); otherwise -> S_ERROR.
REQ-022 Digit accepted while battery count == BATS_PER_BANK (missing newline) -> S_ERROR, no write.
REQ-023 Digit accepted while pointer == all-ones (no room left for EOT) -> S_ERROR, no write.
REQ-024 Any other byte value, including EOT arriving on input -> S_ERROR, no write.
REQ-025 InLast on an accepted byte: process the byte first per REQ-019..024; then, if the post-update battery count == BATS_PER_BANK, close the bank (BankCount +1) and go to S_TERM; if it is 0, go to S_TERM; otherwise go to S_ERROR.
REQ-026 S_TERM: for one cycle, write 8'h04 at the pointer (WrEn registered, per REQ-018); then go to S_DONE.
REQ-027 S_DONE: Done=1; S_ERROR: Error=1; both are absorbing until reset; Done and Error are never both 1.
REQ-028 The battery counter SHALL be $clog2(BATS_PER_BANK)+1 bits wide; the pointer is RomAddr_t with no wrap-around (REQ-023 prevents it).
REQ-029 Reset outputs: InReady=0, WrEn=0, WrAddr=0, WrData=0, BankCount=0, Done=0, Error=0.

Reset
REQ-030 Rst_n=0 on any clock edge SHALL return every register to its reset value and the FSM to S_IDLE, including mid-load, in S_TERM, and in S_DONE/S_ERROR; no write is issued in the cycle after a reset edge.
REQ-031 Memory contents are not cleared by reset; a reload overwrites from address 0.

Structure
REQ-032 RomAddr_t and the ASCII constants (EOT 8'h04, LF 8'h0A, CR 8'h0D, '0'/'9') SHALL live in AocPkg, shared with the solver.
REQ-033 Single module with one registered state struct; no sub-module is required.

Verification
REQ-034 BATS_PER_BANK=4, input "1234\n5678\n" with InLast on the final '\n' -> writes 0..7 = '1'..'8', addr 8 = 8'h04, BankCount=2, Done=1.
REQ-035 Input "1234\r\n9876" with InLast on '6' -> CR is not written; addr 8 = EOT; BankCount=2; Done=1.
REQ-036 Input "123\n" -> Error=1 on the newline; WrEn is never asserted after the error; InReady=0.
REQ-037 Input "12345" -> the 5th digit sets Error, and address 4 is never written.
REQ-038 InValid toggled randomly with a stall inserted mid-bank -> the written image is identical to the unstalled case; every write lands 1 cycle after its transfer.
REQ-039 Rst_n pulsed low after 3 accepted digits, then "4321\n" with InLast -> writes start again at addr 0, EOT at addr 4, BankCount=1.
